rle_line_packer: RTL and testbench
==================================

# rle_line_packer

Run-length encoder between the pixel clock-domain-crossing FIFO (read side, `CLK` domain) and the UART byte transmitter. It pops captured pixels one at a time, collapses consecutive identical pixels within a video line into (count, pixel) records, and serialises each record as bytes to the UART. An end-of-line marker closes every line.

## Interface
- `FrameWidth`, 640, pixels per line; the line counter wraps after this many pops.
- `PixelBitWidth`, 16, pixel width; must be a multiple of 8 (8..32).
- `MaxRun`, 255, longest run in one record; range 1..255.
- `CLK`  in  1  system clock; the block's only clock.
- `RST`  in  1  synchronous, active-high reset.
- `i_pixel`  in  PixelBitWidth  FIFO read data; valid in the cycle after `o_rd_en`.
- `i_empty`  in  1  FIFO empty flag.
- `o_rd_en`  out  1  FIFO pop strobe, one cycle wide.
- `i_uart_busy`  in  1  UART is shifting a byte; no `o_send` is accepted while high.
- `o_frame`  out  8  byte to transmit; held stable from `o_send` until the next `o_send`.
- `o_send`  out  1  one-cycle strobe that loads `o_frame` into the UART.
- `o_line_done`  out  1  one-cycle pulse in the cycle the end-of-line marker is sent.

## Operation
- Record format: count byte (1..MaxRun), then the pixel bytes, MSB first (PixelBitWidth/8 bytes).
- End-of-line marker: single byte 0x00, sent after the last record of each line.
- Registers:
  - `col`: pixels popped in the current line, 0..FrameWidth-1.
  - `run_pix`, `run_cnt` (8 bit): the open run.
  - `pend_pix`, `pend_valid`: a pixel that broke a run and still needs a run of its own.
  - `byte_idx`: byte pointer within a record.
- States:
  - FETCH: `o_rd_en = !i_empty` (combinational). When it pops, go to SAMPLE. While `i_empty` is high, stay in FETCH.
  - SAMPLE: compare `i_pixel` with the open run.
    - First pixel of the line (`run_cnt == 0`): open a run with count 1.
    - Equal pixel and `run_cnt < MaxRun`: increment `run_cnt`.
    - Otherwise (different pixel, or the run is full): store the pixel in `pend_pix`, set `pend_valid`, go to EMIT.
    - If `col == FrameWidth-1`: set the `eol` flag and go to EMIT, with the pixel either absorbed into the run or pending per the rules above. Otherwise increment `col` and return to FETCH.
  - EMIT: send the count byte, then the pixel bytes. After the last byte:
    - If `pend_valid`: `run_pix` ← `pend_pix`, `run_cnt` ← 1, clear `pend_valid`. If `eol` is set, emit again (the 1-pixel run); otherwise return to FETCH.
    - Else if `eol` is set: go to EOL.
    - Otherwise: go to FETCH.
  - EOL: send 0x00 and pulse `o_line_done`. Then clear `col`, `run_cnt` and `eol`, and go to FETCH.
- Byte handshake: `o_send` is issued only when `i_uart_busy == 0` and no `o_send` occurred in the previous cycle. The guard cycle covers the UART's one-cycle busy rise.
- Records never span lines. A run is never longer than MaxRun or FrameWidth.
- No pops occur during EMIT or EOL. Back-pressure reaches the FIFO through its full flag; FIFO overflow is upstream's concern.

## Timing
- Reset values: `o_rd_en` 0, `o_send` 0, `o_frame` 0x00, `o_line_done` 0, state FETCH, all counters and flags 0.
- `RST` mid-operation: the open run, pending pixel and partial record are discarded. The next pop is treated as pixel 0 of a new line.
- Pop to compare: `i_pixel` is sampled exactly 1 cycle after `o_rd_en`. Best case is one pixel per 2 cycles.
- First `o_send` of a record: no earlier than 1 cycle after entering EMIT.
- Successive bytes: at least 2 cycles apart, gated by `i_uart_busy`.
- `o_line_done` is coincident with the `o_send` that carries 0x00.
- `i_empty` rising in FETCH: `o_rd_en` stays low; the line is not terminated early.

## Test plan
- Setup: FrameWidth=8, PixelBitWidth=16, MaxRun=255, UART model busy for 10 cycles after each `o_send`.
- Uniform line, 8× 0xABCD → bytes 08 AB CD 00; `o_line_done` pulses once with the 00 byte.
- Alternating line, A=0x1111, B=0x2222 (A B A B A B A B) → eight records 01 xx xx, then 00. The last pixel differs from its predecessor, which exercises pending plus `eol`.
- MaxRun=3, uniform line of 0x00FF → 03 00 FF, 03 00 FF, 02 00 FF, 00.
- Hold `i_empty` high for 50 cycles after pixel 3 → no `o_rd_en` and no `o_send` during the stall. Output is identical to the unstalled run.
- Hold `i_uart_busy` high for 100 cycles mid-record:
  - `o_frame` stays stable and `o_send` stays low throughout.
  - The record resumes with the next byte, and no byte is lost or duplicated.
- Assert `RST` for 1 cycle after pixel 5:
  - All outputs read 0 on the next cycle.
  - The following 8 pixels produce a complete, fresh line ending in 00.

Source files
------------

// File: rtl/rle_line_packer_if.sv
// Handshake bundle shared by the pixel FIFO read port, the RLE line packer and the UART byte transmitter.
interface rle_line_packer_if #(
  parameter int PixelBitWidth = 16
);
  logic [PixelBitWidth-1:0] i_pixel;
  logic                     i_empty;
  logic                     o_rd_en;
  logic                     i_uart_busy;
  logic [7:0]               o_frame;
  logic                     o_send;
  logic                     o_line_done;

  // master is the FIFO/UART environment, slave is the packer itself
  modport master (
    output i_pixel, i_empty, i_uart_busy,
    input  o_rd_en, o_frame, o_send, o_line_done
  );

  modport slave (
    input  i_pixel, i_empty, i_uart_busy,
    output o_rd_en, o_frame, o_send, o_line_done
  );
endinterface

// File: rtl/rle_line_packer.sv
// Run-length encoder: pops pixels from the CDC FIFO, merges equal neighbours within a line into
// (count, pixel) records and streams them byte-wise to the UART, closing each line with 0x00.
module rle_line_packer #(
  parameter int FrameWidth    = 640,
  parameter int PixelBitWidth = 16,
  parameter int MaxRun        = 255
) (
  input logic              CLK,
  input logic              RST,
  rle_line_packer_if.slave bus
);
  localparam int NumBytes = PixelBitWidth / 8;
  localparam int ColW     = (FrameWidth > 1) ? $clog2(FrameWidth) : 1;
  localparam int IdxW     = $clog2(NumBytes + 1);

  localparam logic [ColW-1:0] LastCol  = ColW'(FrameWidth - 1);
  localparam logic [7:0]      RunLimit = 8'(MaxRun);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NumBytes);

  typedef enum logic [1:0] {FETCH, SAMPLE, EMIT, EOL} state_t;

  state_t                   state;
  state_t                   state_next;
  logic [ColW-1:0]          col;
  logic [PixelBitWidth-1:0] run_pix;
  logic [PixelBitWidth-1:0] pend_pix;
  logic [7:0]               run_cnt;
  logic                     pend_valid;
  logic                     eol;
  logic [IdxW-1:0]          byte_idx;
  logic                     sent_q;
  logic [7:0]               frame_q;

  logic                     pop;
  logic                     send;
  logic                     run_break;
  logic                     at_eol;
  logic [7:0]               cur_byte;

  // byte_idx 0 selects the count byte, 1..NumBytes walk the pixel MSB first
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    send       = 1'b0;
    run_break  = (run_cnt != 8'd0) && ((bus.i_pixel != run_pix) || (run_cnt >= RunLimit));
    at_eol     = (col == LastCol);
    cur_byte   = run_cnt;
    for (int k = 0; k < NumBytes; k++) begin
      if (byte_idx == IdxW'(k + 1)) cur_byte = run_pix[(NumBytes-1-k)*8 +: 8];
    end

    case (state)
      FETCH: begin
        pop = !bus.i_empty && !RST;
        if (pop) state_next = SAMPLE;
      end
      SAMPLE: begin
        state_next = (run_break || at_eol) ? EMIT : FETCH;
      end
      EMIT: begin
        // the guard cycle after a send covers the UART's one-cycle busy rise
        send = !bus.i_uart_busy && !sent_q && !RST;
        if (send && byte_idx == LastIdx) begin
          if (pend_valid)  state_next = eol ? EMIT : FETCH;
          else if (eol)    state_next = EOL;
          else             state_next = FETCH;
        end
      end
      EOL: begin
        cur_byte = 8'h00;
        send     = !bus.i_uart_busy && !sent_q && !RST;
        if (send) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  assign bus.o_rd_en     = pop;
  assign bus.o_send      = send;
  assign bus.o_frame     = send ? cur_byte : frame_q;
  assign bus.o_line_done = send && (state == EOL);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= FETCH;
      col        <= '0;
      run_pix    <= '0;
      pend_pix   <= '0;
      run_cnt    <= 8'd0;
      pend_valid <= 1'b0;
      eol        <= 1'b0;
      byte_idx   <= '0;
      sent_q     <= 1'b0;
      frame_q    <= 8'h00;
    end else begin
      state  <= state_next;
      sent_q <= send;
      if (send) frame_q <= cur_byte;

      case (state)
        SAMPLE: begin
          if (run_cnt == 8'd0) begin
            run_pix <= bus.i_pixel;
            run_cnt <= 8'd1;
          end else if (!run_break) begin
            run_cnt <= run_cnt + 8'd1;
          end else begin
            pend_pix   <= bus.i_pixel;
            pend_valid <= 1'b1;
          end
          if (at_eol) eol <= 1'b1;
          else        col <= col + 1'b1;
        end
        EMIT: begin
          if (send) begin
            if (byte_idx == LastIdx) begin
              byte_idx <= '0;
              // the pixel that broke the run becomes a fresh run of one
              if (pend_valid) begin
                run_pix    <= pend_pix;
                run_cnt    <= 8'd1;
                pend_valid <= 1'b0;
              end
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        EOL: begin
          if (send) begin
            col     <= '0;
            run_cnt <= 8'd0;
            eol     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rle_line_packer.sv
// Bench for rle_line_packer: two packers (MaxRun 255 and 3) receive identical lines and each
// byte stream is compared with a greedy run-splitting model of the record format.
module tb_rle_line_packer;
  localparam int FW = 8;
  localparam int PW = 16;
  localparam int NB = PW / 8;

  typedef logic [8:0]    ent_t;
  typedef logic [PW-1:0] line_t [FW];

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  rle_line_packer_if #(.PixelBitWidth(PW)) bus [2] ();

  rle_line_packer #(.FrameWidth(FW), .PixelBitWidth(PW), .MaxRun(255)) dut_long (
    .CLK(CLK), .RST(RST), .bus(bus[0])
  );
  rle_line_packer #(.FrameWidth(FW), .PixelBitWidth(PW), .MaxRun(3)) dut_short (
    .CLK(CLK), .RST(RST), .bus(bus[1])
  );

  int            checks   = 0;
  int            failures = 0;
  int            max_run [2] = '{255, 3};
  ent_t          exp_q [2][$];
  ent_t          last_model [2][$];
  ent_t          model_q [$];
  logic [PW-1:0] fifo_q [2][$];
  logic          stall = 1'b0;
  logic          hold  = 1'b0;
  logic          gaps  = 1'b0;
  logic          quiet = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // entries are {is_eol_marker, byte}; runs split greedily at MaxRun and never cross the line
  task automatic buildModel(input int maxrun, input line_t ln);
    int i;
    int j;
    model_q.delete();
    i = 0;
    while (i < FW) begin
      j = i + 1;
      while (j < FW && ln[j] == ln[i] && (j - i) < maxrun) j++;
      model_q.push_back({1'b0, 8'(j - i)});
      for (int b = NB - 1; b >= 0; b--) model_q.push_back({1'b0, ln[i][b*8 +: 8]});
      i = j;
    end
    model_q.push_back({1'b1, 8'h00});
  endtask

  task automatic loadModel(input line_t ln);
    for (int c = 0; c < 2; c++) begin
      buildModel(max_run[c], ln);
      last_model[c] = model_q;
      foreach (model_q[k]) exp_q[c].push_back(model_q[k]);
    end
  endtask

  task automatic checkModel(input string name, input int c, input ent_t lit [$]);
    logic ok;
    ok = (last_model[c].size() == lit.size());
    if (ok) foreach (lit[k]) if (last_model[c][k] !== lit[k]) ok = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL %s: model gave %0d entries, required %0d with matching contents",
               name, last_model[c].size(), lit.size());
    end
  endtask

  task automatic applyStimulus(input line_t ln, input int first, input int count);
    for (int k = first; k < first + count; k++) begin
      fifo_q[0].push_back(ln[k]);
      fifo_q[1].push_back(ln[k]);
    end
  endtask

  task automatic waitDrain(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (exp_q[0].size() == 0 && exp_q[1].size() == 0 && fifo_q[0].size() == 0 && fifo_q[1].size() == 0) break;
      @(posedge CLK);
    end
    checks++;
    if (k == budget) begin
      failures++;
      $display("[TB] FAIL %s drain: bytes left %0d/%0d, pixels left %0d/%0d, required all 0",
               name, exp_q[0].size(), exp_q[1].size(), fifo_q[0].size(), fifo_q[1].size());
      exp_q[0].delete(); exp_q[1].delete(); fifo_q[0].delete(); fifo_q[1].delete();
    end
    repeat (30) @(posedge CLK);
    #1;
  endtask

  task automatic waitQueueLevel(input string name, input int c, input int level, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (exp_q[c].size() <= level) break;
      @(posedge CLK);
    end
    #1;
    checks++;
    if (k == budget) begin
      failures++;
      $display("[TB] FAIL %s: %0d bytes still pending, required at most %0d", name, exp_q[c].size(), level);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " ch0 o_rd_en"},     32'(bus[0].o_rd_en),     0);
    checkOutput({tag, " ch0 o_send"},      32'(bus[0].o_send),      0);
    checkOutput({tag, " ch0 o_frame"},     32'(bus[0].o_frame),     0);
    checkOutput({tag, " ch0 o_line_done"}, 32'(bus[0].o_line_done), 0);
    checkOutput({tag, " ch1 o_rd_en"},     32'(bus[1].o_rd_en),     0);
    checkOutput({tag, " ch1 o_send"},      32'(bus[1].o_send),      0);
    checkOutput({tag, " ch1 o_frame"},     32'(bus[1].o_frame),     0);
    checkOutput({tag, " ch1 o_line_done"}, 32'(bus[1].o_line_done), 0);
  endtask

  // per channel: FIFO and UART models plus the cycle-by-cycle compare against the expected bytes
  for (genvar c = 0; c < 2; c++) begin : g_ch
    initial begin
      logic       rd;
      logic       snd;
      logic       prev_send;
      logic [7:0] last_frame;
      int         busy_cnt;
      ent_t       e;
      prev_send  = 1'b0;
      last_frame = 8'h00;
      busy_cnt   = 0;
      bus[c].i_pixel     = '0;
      bus[c].i_empty     = 1'b1;
      bus[c].i_uart_busy = 1'b0;
      forever begin
        @(negedge CLK);
        rd  = bus[c].o_rd_en;
        snd = bus[c].o_send;
        if (RST) begin
          prev_send  = 1'b0;
          last_frame = 8'h00;
        end else begin
          checkOutput($sformatf("ch%0d rd_en_while_empty", c), 32'(rd && bus[c].i_empty), 0);
          if (snd) begin
            checkOutput($sformatf("ch%0d send_while_busy", c), 32'(bus[c].i_uart_busy), 0);
            checkOutput($sformatf("ch%0d send_back_to_back", c), 32'(prev_send), 0);
            checkOutput($sformatf("ch%0d send_during_stall", c), 32'(quiet), 0);
            if (exp_q[c].size() == 0) begin
              checks++;
              failures++;
              $display("[TB] FAIL ch%0d unexpected_byte: got 0x%0h, required no send", c, bus[c].o_frame);
            end else begin
              e = exp_q[c].pop_front();
              checkOutput($sformatf("ch%0d byte", c), 32'(bus[c].o_frame), 32'(e[7:0]));
              checkOutput($sformatf("ch%0d line_done", c), 32'(bus[c].o_line_done), 32'(e[8]));
            end
            last_frame = bus[c].o_frame;
          end else begin
            checkOutput($sformatf("ch%0d frame_stable", c), 32'(bus[c].o_frame), 32'(last_frame));
            checkOutput($sformatf("ch%0d line_done_idle", c), 32'(bus[c].o_line_done), 0);
          end
          prev_send = snd;
        end
        @(posedge CLK);
        #1;
        // pixel data is only meaningful in the cycle after a pop; garbage otherwise
        if (rd && fifo_q[c].size() > 0) bus[c].i_pixel = fifo_q[c].pop_front();
        else                            bus[c].i_pixel = PW'($urandom);
        if (snd)               busy_cnt = 10;
        else if (busy_cnt > 0) busy_cnt--;
        bus[c].i_uart_busy = (busy_cnt > 0) || hold;
        bus[c].i_empty = (fifo_q[c].size() == 0) || stall || (gaps && ($urandom_range(0, 2) == 0));
      end
    end
  end

  initial begin
    #2000000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    line_t         ln;
    ent_t          lit [$];
    logic [PW-1:0] palette [4];

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    checkResetOutputs("reset");

    $display("[TB] uniform line 0xABCD");
    ln = '{default: 16'hABCD};
    loadModel(ln);
    lit = '{9'h008, 9'h0AB, 9'h0CD, 9'h100};
    checkModel("model uniform long", 0, lit);
    lit = '{9'h003, 9'h0AB, 9'h0CD, 9'h003, 9'h0AB, 9'h0CD, 9'h002, 9'h0AB, 9'h0CD, 9'h100};
    checkModel("model uniform short", 1, lit);
    applyStimulus(ln, 0, FW);
    waitDrain("uniform", 4000);

    $display("[TB] alternating line");
    for (int k = 0; k < FW; k++) ln[k] = (k % 2 == 1) ? 16'h2222 : 16'h1111;
    loadModel(ln);
    lit = '{9'h001, 9'h011, 9'h011, 9'h001, 9'h022, 9'h022, 9'h001, 9'h011, 9'h011,
            9'h001, 9'h022, 9'h022, 9'h001, 9'h011, 9'h011, 9'h001, 9'h022, 9'h022,
            9'h001, 9'h011, 9'h011, 9'h001, 9'h022, 9'h022, 9'h100};
    checkModel("model alternating", 0, lit);
    applyStimulus(ln, 0, FW);
    waitDrain("alternating", 4000);

    $display("[TB] uniform line 0x00FF");
    ln = '{default: 16'h00FF};
    loadModel(ln);
    lit = '{9'h003, 9'h000, 9'h0FF, 9'h003, 9'h000, 9'h0FF, 9'h002, 9'h000, 9'h0FF, 9'h100};
    checkModel("model maxrun split", 1, lit);
    applyStimulus(ln, 0, FW);
    waitDrain("maxrun", 4000);

    $display("[TB] FIFO stall after pixel 3");
    ln = '{default: 16'h5555};
    loadModel(ln);
    applyStimulus(ln, 0, 3);
    waitQueueLevel("stall prefill", 0, 1000, 200);
    while (fifo_q[0].size() != 0 || fifo_q[1].size() != 0) @(posedge CLK);
    repeat (4) @(posedge CLK);
    #1;
    stall = 1'b1;
    quiet = 1'b1;
    repeat (50) @(posedge CLK);
    #1;
    stall = 1'b0;
    quiet = 1'b0;
    applyStimulus(ln, 3, FW - 3);
    waitDrain("stall", 4000);

    $display("[TB] UART busy held mid-record");
    for (int k = 0; k < FW; k++) ln[k] = (k % 2 == 1) ? 16'h3C3C : 16'hC3C3;
    loadModel(ln);
    applyStimulus(ln, 0, FW);
    waitQueueLevel("busy hold start", 0, 23, 1000);
    hold = 1'b1;
    repeat (100) @(posedge CLK);
    #1;
    hold = 1'b0;
    waitDrain("busy hold", 4000);

    $display("[TB] reset after pixel 5");
    ln = '{16'h0A0A, 16'h0A0A, 16'h0B0B, 16'h0B0B, 16'h0C0C, 16'h0C0C, 16'h0C0C, 16'h0D0D};
    loadModel(ln);
    applyStimulus(ln, 0, 5);
    while (fifo_q[0].size() != 0 || fifo_q[1].size() != 0) @(posedge CLK);
    repeat (20) @(posedge CLK);
    #1;
    RST = 1'b1;
    exp_q[0].delete();
    exp_q[1].delete();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    checkResetOutputs("mid reset");
    ln = '{16'h0001, 16'h0001, 16'h0001, 16'h0002, 16'h0002, 16'h0003, 16'h0003, 16'h0003};
    loadModel(ln);
    applyStimulus(ln, 0, FW);
    waitDrain("after reset", 4000);

    $display("[TB] random lines");
    gaps = 1'b1;
    for (int batch = 0; batch < 6; batch++) begin
      palette = '{16'h0000, 16'hFFFF, 16'h00FF, PW'($urandom)};
      for (int n = 0; n < 3; n++) begin
        for (int k = 0; k < FW; k++) begin
          if (k == 0 || $urandom_range(0, 2) == 0) ln[k] = palette[$urandom_range(0, 3)];
          else                                     ln[k] = ln[k-1];
        end
        loadModel(ln);
        applyStimulus(ln, 0, FW);
      end
      waitDrain("random", 8000);
    end
    gaps = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
